// File: rtl/cmd_pkg.sv
// cmd_pkg: frame geometry, command opcodes and FSM states shared by the SPI
// front end and the control state machine.
package cmd_pkg;
  localparam int FRM_BITS = 24;
  localparam int RSP_BITS = 16;
  localparam int OPC_MSB = 23;
  localparam int OPC_LSB = 14;
  localparam int OPC_BITS = OPC_MSB - OPC_LSB + 1;
  localparam int EEP_ADDR_MSB = 17;
  localparam int EEP_ADDR_LSB = 16;
  localparam logic [OPC_BITS-1:0] NEW_XSET = 10'h300;
  localparam logic [OPC_BITS-1:0] START_CM = 10'h003;
  localparam logic [OPC_BITS-1:0] WRT_EEP = 10'h0C0;
  // READ_EEP carries the EEPROM address in cfg_data[17:16]; those bits are zero here
  localparam logic [OPC_BITS-1:0] READ_EEP = 10'h100;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CHECK  = 2'd2
  } state_e;
endpackage

// File: rtl/cmd_spi_intf_if.sv
// cmd_spi_intf_if: command/response handshake between the SPI front end
// (slave) and the control state machine (master).
interface cmd_spi_intf_if #(
  parameter int FRM_BITS = cmd_pkg::FRM_BITS,
  parameter int RSP_BITS = cmd_pkg::RSP_BITS
);
  logic [FRM_BITS-1:0] cfg_data;
  logic                frm_rdy;
  logic                clr_rdy;
  logic                snd_rsp;
  logic [RSP_BITS-1:0] rsp_data;
  logic                rsp_pend;
  logic                frm_err;
  modport master (
    input  cfg_data, frm_rdy, rsp_pend, frm_err,
    output clr_rdy, snd_rsp, rsp_data
  );
  modport slave (
    output cfg_data, frm_rdy, rsp_pend, frm_err,
    input  clr_rdy, snd_rsp, rsp_data
  );
endinterface

// File: rtl/sync_edge.sv
// sync_edge: two-flop synchronizer plus a history flop so that rise/fall are
// single-cycle pulses on the synchronized level.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [2:0] sh_q, sh_d;
  always_comb sh_d = {sh_q[1:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= {3{RST_VAL}};
    else sh_q <= sh_d;
  assign sync = sh_q[1];
  assign rise = sh_q[1] & ~sh_q[2];
  assign fall = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/cmd_spi_intf.sv
// cmd_spi_intf: SPI mode-0 command receiver and response transmitter; frames
// are length-checked on SS_n rise before being handed to the control FSM.
module cmd_spi_intf #(
  parameter int FRM_BITS = cmd_pkg::FRM_BITS,
  parameter int RSP_BITS = cmd_pkg::RSP_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  cmd_spi_intf_if.slave bus
);
  import cmd_pkg::*;
  logic ss_unused, ss_rise, ss_fall;
  logic sclk_unused, sclk_rise, sclk_fall;
  logic mosi_s;
  logic [1:0] mosi_unused;
  sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst_n(rst_n), .d(SS_n), .sync(ss_unused), .rise(ss_rise), .fall(ss_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(SCLK), .sync(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(MOSI), .sync(mosi_s), .rise(mosi_unused[0]), .fall(mosi_unused[1])
  );
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [FRM_BITS-1:0] rx_q, rx_d, cfg_q, cfg_d;
  logic [RSP_BITS-1:0] tx_q, tx_d, tx_buf_q, tx_buf_d;
  logic rsp_pend_q, rsp_pend_d, frm_rdy_q, frm_rdy_d, frm_err_q, frm_err_d, miso_q, miso_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    cfg_d = cfg_q;
    rsp_pend_d = rsp_pend_q;
    tx_buf_d = bus.snd_rsp ? bus.rsp_data : tx_buf_q;
    frm_rdy_d = bus.clr_rdy ? 1'b0 : frm_rdy_q;
    frm_err_d = 1'b0;
    miso_d = (state_q == ACTIVE) & tx_q[RSP_BITS-1];
    case (state_q)
      IDLE:
        if (ss_fall) begin
          state_d = ACTIVE;
          cnt_d = '0;
          tx_d = rsp_pend_q ? tx_buf_q : '0;
          rsp_pend_d = 1'b0;
        end
      ACTIVE:
        if (ss_rise) state_d = CHECK;
        else begin
          if (sclk_rise) begin
            rx_d = {rx_q[FRM_BITS-2:0], mosi_s};
            cnt_d = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
          end
          if (sclk_fall) tx_d = {tx_q[RSP_BITS-2:0], 1'b0};
        end
      CHECK: begin
        state_d = IDLE;
        if (cnt_q == 5'(FRM_BITS)) begin
          cfg_d = rx_q;
          frm_rdy_d = 1'b1;
          frm_err_d = frm_rdy_q;
        end else frm_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // a response loaded in the frame-start cycle waits for the next frame
    if (bus.snd_rsp) rsp_pend_d = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      tx_buf_q <= '0;
      cfg_q <= '0;
      rsp_pend_q <= 1'b0;
      frm_rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      tx_buf_q <= tx_buf_d;
      cfg_q <= cfg_d;
      rsp_pend_q <= rsp_pend_d;
      frm_rdy_q <= frm_rdy_d;
      frm_err_q <= frm_err_d;
      miso_q <= miso_d;
    end
  assign MISO = miso_q;
  assign bus.cfg_data = cfg_q;
  assign bus.frm_rdy = frm_rdy_q;
  assign bus.rsp_pend = rsp_pend_q;
  assign bus.frm_err = frm_err_q;
endmodule

// File: tb/tb_cmd_spi_intf.sv
// tb_cmd_spi_intf: directed SPI frames with hand-computed expectations for
// cmd_spi_intf.
module tb_cmd_spi_intf;
  logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic MISO;
  cmd_spi_intf_if bus();
  cmd_spi_intf dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, err_cnt = 0;
  logic [31:0] miso_bits;
  logic pend_start, rdy_pre, rdy_post, err_post;
  always @(negedge clk) if (bus.frm_err === 1'b1) err_cnt++;
  task automatic pulse_clr();
    @(negedge clk);
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    @(negedge clk);
  endtask
  task automatic pulse_snd(input logic [15:0] val);
    @(negedge clk);
    bus.snd_rsp = 1'b1;
    bus.rsp_data = val;
    @(negedge clk);
    bus.snd_rsp = 1'b0;
  endtask
  task automatic spi_start(input logic snd, input logic [15:0] val);
    @(negedge clk);
    SS_n = 1'b0;
    repeat (2) @(negedge clk);
    if (snd) begin
      bus.snd_rsp = 1'b1;
      bus.rsp_data = val;
    end
    @(negedge clk);
    bus.snd_rsp = 1'b0;
    pend_start = bus.rsp_pend;
    repeat (2) @(negedge clk);
  endtask
  task automatic spi_bits(input logic [31:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = data[i];
      repeat (5) @(negedge clk);
      miso_bits = {miso_bits[30:0], MISO};
      SCLK = 1'b1;
      repeat (5) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (5) @(negedge clk);
  endtask
  task automatic spi_end(input logic clr);
    SS_n = 1'b1;
    repeat (3) @(negedge clk);
    rdy_pre = bus.frm_rdy;
    if (clr) bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    rdy_post = bus.frm_rdy;
    err_post = bus.frm_err;
    repeat (6) @(negedge clk);
  endtask
  task automatic spi_frame(input logic [31:0] data, input int nbits, input logic snd,
                           input logic [15:0] val, input logic clr);
    miso_bits = '0;
    spi_start(snd, val);
    spi_bits(data, nbits);
    spi_end(clr);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (MISO !== 1'b0) begin n_bad++; $display("FAIL reset_miso: got %b want 0", MISO); end
    n_cmp++; if (bus.cfg_data !== 24'h0) begin n_bad++; $display("FAIL reset_cfg: got %h want 000000", bus.cfg_data); end
    n_cmp++; if (bus.frm_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_rdy: got %b want 0", bus.frm_rdy); end
    n_cmp++; if (bus.rsp_pend !== 1'b0) begin n_bad++; $display("FAIL reset_pend: got %b want 0", bus.rsp_pend); end
    n_cmp++; if (bus.frm_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.frm_err); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  task automatic test_good_frame();
    int e0;
    e0 = err_cnt;
    spi_frame(32'hC03A5C, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (rdy_pre !== 1'b0) begin n_bad++; $display("FAIL good_rdy_early: got %b want 0", rdy_pre); end
    n_cmp++; if (rdy_post !== 1'b1) begin n_bad++; $display("FAIL good_rdy: got %b want 1", rdy_post); end
    n_cmp++; if (bus.cfg_data !== 24'hC03A5C) begin n_bad++; $display("FAIL good_cfg: got %h want c03a5c", bus.cfg_data); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL good_err: got %0d pulses want 0", err_cnt - e0); end
    pulse_clr();
    n_cmp++; if (bus.frm_rdy !== 1'b0) begin n_bad++; $display("FAIL clr_rdy: got %b want 0", bus.frm_rdy); end
    n_cmp++; if (bus.cfg_data !== 24'hC03A5C) begin n_bad++; $display("FAIL clr_cfg_hold: got %h want c03a5c", bus.cfg_data); end
  endtask
  task automatic test_response();
    pulse_snd(16'h2ABC);
    n_cmp++; if (bus.rsp_pend !== 1'b1) begin n_bad++; $display("FAIL rsp_pend_set: got %b want 1", bus.rsp_pend); end
    spi_frame(32'h123456, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (pend_start !== 1'b0) begin n_bad++; $display("FAIL rsp_pend_clr: got %b want 0", pend_start); end
    n_cmp++; if (miso_bits[23:0] !== 24'h2ABC00) begin n_bad++; $display("FAIL rsp_miso: got %h want 2abc00", miso_bits[23:0]); end
    n_cmp++; if (bus.cfg_data !== 24'h123456) begin n_bad++; $display("FAIL rsp_cfg: got %h want 123456", bus.cfg_data); end
    pulse_clr();
    spi_frame(32'h654321, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (miso_bits[23:0] !== 24'h0) begin n_bad++; $display("FAIL rsp_empty: got %h want 000000", miso_bits[23:0]); end
  endtask
  task automatic test_bad_length();
    int e0;
    e0 = err_cnt;
    spi_frame(32'h0ABCDE, 23, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (err_post !== 1'b1) begin n_bad++; $display("FAIL bad23_err_time: got %b want 1", err_post); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL bad23_err: got %0d pulses want 1", err_cnt - e0); end
    n_cmp++; if (bus.cfg_data !== 24'h654321) begin n_bad++; $display("FAIL bad23_cfg: got %h want 654321", bus.cfg_data); end
    n_cmp++; if (bus.frm_rdy !== 1'b1) begin n_bad++; $display("FAIL bad23_rdy: got %b want 1", bus.frm_rdy); end
    e0 = err_cnt;
    spi_frame(32'h1FFFFFF, 25, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL bad25_err: got %0d pulses want 1", err_cnt - e0); end
    n_cmp++; if (bus.cfg_data !== 24'h654321) begin n_bad++; $display("FAIL bad25_cfg: got %h want 654321", bus.cfg_data); end
    n_cmp++; if (bus.frm_rdy !== 1'b1) begin n_bad++; $display("FAIL bad25_rdy: got %b want 1", bus.frm_rdy); end
  endtask
  task automatic test_overrun();
    int e0;
    pulse_clr();
    e0 = err_cnt;
    spi_frame(32'h000C00, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL ovr_first_err: got %0d pulses want 0", err_cnt - e0); end
    e0 = err_cnt;
    spi_frame(32'h00C000, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (bus.cfg_data !== 24'h00C000) begin n_bad++; $display("FAIL ovr_cfg: got %h want 00c000", bus.cfg_data); end
    n_cmp++; if (bus.frm_rdy !== 1'b1) begin n_bad++; $display("FAIL ovr_rdy: got %b want 1", bus.frm_rdy); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL ovr_err: got %0d pulses want 1", err_cnt - e0); end
  endtask
  task automatic test_clr_collision();
    pulse_clr();
    spi_frame(32'h5A5A5A, 24, 1'b0, 16'h0, 1'b1);
    n_cmp++; if (rdy_post !== 1'b1) begin n_bad++; $display("FAIL clr_coll_rdy: got %b want 1", rdy_post); end
    n_cmp++; if (bus.frm_rdy !== 1'b1) begin n_bad++; $display("FAIL clr_coll_hold: got %b want 1", bus.frm_rdy); end
    n_cmp++; if (bus.cfg_data !== 24'h5A5A5A) begin n_bad++; $display("FAIL clr_coll_cfg: got %h want 5a5a5a", bus.cfg_data); end
  endtask
  task automatic test_snd_collision();
    pulse_clr();
    pulse_snd(16'h1111);
    spi_frame(32'h0F0F0F, 24, 1'b1, 16'h2222, 1'b0);
    n_cmp++; if (miso_bits[23:0] !== 24'h111100) begin n_bad++; $display("FAIL snd_coll_miso: got %h want 111100", miso_bits[23:0]); end
    n_cmp++; if (pend_start !== 1'b1) begin n_bad++; $display("FAIL snd_coll_pend_start: got %b want 1", pend_start); end
    n_cmp++; if (bus.rsp_pend !== 1'b1) begin n_bad++; $display("FAIL snd_coll_pend: got %b want 1", bus.rsp_pend); end
    pulse_clr();
    spi_frame(32'hF0F0F0, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (miso_bits[23:0] !== 24'h222200) begin n_bad++; $display("FAIL snd_coll_next: got %h want 222200", miso_bits[23:0]); end
    n_cmp++; if (bus.rsp_pend !== 1'b0) begin n_bad++; $display("FAIL snd_coll_pend_end: got %b want 0", bus.rsp_pend); end
  endtask
  task automatic test_reset_midframe();
    int e0;
    miso_bits = '0;
    spi_start(1'b0, 16'h0);
    spi_bits(32'h3FF, 10);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cfg_data !== 24'h0) begin n_bad++; $display("FAIL mid_rst_cfg: got %h want 000000", bus.cfg_data); end
    n_cmp++; if (bus.frm_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rdy: got %b want 0", bus.frm_rdy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e0 = err_cnt;
    repeat (5) @(negedge clk);
    spi_bits(32'h1234, 14);
    spi_end(1'b0);
    n_cmp++; if (err_post !== 1'b1) begin n_bad++; $display("FAIL mid_err_time: got %b want 1", err_post); end
    n_cmp++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL mid_err: got %0d pulses want 1", err_cnt - e0); end
    n_cmp++; if (bus.frm_rdy !== 1'b0) begin n_bad++; $display("FAIL mid_rdy: got %b want 0", bus.frm_rdy); end
    e0 = err_cnt;
    spi_frame(32'hABCDEF, 24, 1'b0, 16'h0, 1'b0);
    n_cmp++; if (rdy_post !== 1'b1) begin n_bad++; $display("FAIL mid_next_rdy: got %b want 1", rdy_post); end
    n_cmp++; if (bus.cfg_data !== 24'hABCDEF) begin n_bad++; $display("FAIL mid_next_cfg: got %h want abcdef", bus.cfg_data); end
    n_cmp++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL mid_next_err: got %0d pulses want 0", err_cnt - e0); end
  endtask
  initial begin
    bus.clr_rdy = 1'b0;
    bus.snd_rsp = 1'b0;
    bus.rsp_data = 16'h0;
    test_reset();
    test_good_frame();
    test_response();
    test_bad_length();
    test_overrun();
    test_clr_collision();
    test_snd_collision();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmd_spi_intf.md
# cmd_spi_intf

Serial command front end for the PID controller. It receives 24-bit command frames from the host over an SPI-mode-0 link and presents them to the math/control state machine as `cfg_data` with an `frm_rdy` flag; the state machine clears the flag with `clr_rdy`. It also returns 16-bit responses: the state machine loads one with `snd_rsp`, and the block shifts it out on MISO during the next frame. It sits between the chip pins and the control state machine.

## Interface

Parameters:
- FRM_BITS, 24, command frame length in bits
- RSP_BITS, 16, response length in bits

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- SS_n  in  1  host slave select, asynchronous to clk
- SCLK  in  1  host serial clock, asynchronous to clk
- MOSI  in  1  host data to block, asynchronous to clk
- MISO  out  1  block data to host
- cfg_data  out  24  last good command frame, MSB = first bit received
- frm_rdy  out  1  a new frame is held in cfg_data
- clr_rdy  in  1  one-cycle pulse from the state machine; clears frm_rdy
- snd_rsp  in  1  one-cycle pulse; captures rsp_data for transmission
- rsp_data  in  16  response word; top level zero-extends the 14-bit datapath result
- rsp_pend  out  1  a response is loaded and not yet sent
- frm_err  out  1  one-cycle pulse on a bad-length frame or an overrun

## Operation

- **Synchronizers.** SS_n, SCLK and MOSI each pass through 2 flops, then one history flop for edge detection.
  - Reset values: SS_n chain = 1, SCLK chain = 0, MOSI chain = 0.
- **FSM states.** IDLE, ACTIVE, CHECK.
  - IDLE → ACTIVE on a synchronized SS_n fall. On this transition:
    - clear the bit counter (5 bits);
    - load tx_shift from tx_buf if rsp_pend is set, and clear rsp_pend;
    - otherwise load tx_shift with 16'h0000.
  - ACTIVE, on a synchronized SCLK rise: shift rx_shift left with MOSI into the LSB; increment the counter, saturating at 31.
  - ACTIVE, on a synchronized SCLK fall: shift tx_shift left, filling the LSB with 0.
  - ACTIVE → CHECK on a synchronized SS_n rise. Any SCLK edge in that same cycle is ignored.
  - CHECK, always returns to IDLE after one cycle:
    - counter == 24: cfg_data ← rx_shift and frm_rdy ← 1. If frm_rdy was already 1 (overrun), cfg_data is still overwritten and frm_err pulses.
    - counter != 24: cfg_data and frm_rdy are unchanged, and frm_err pulses.
- **MISO.** Driven as tx_shift[15] while synchronized SS_n is low (state ACTIVE); 0 otherwise. The response therefore occupies bit times 1–16, and bits 17–24 read 0.
- **snd_rsp.** tx_buf ← rsp_data and rsp_pend ← 1, accepted in any state.
  - A second snd_rsp before the next frame start overwrites tx_buf.
  - A snd_rsp during ACTIVE is held for the following frame.
  - snd_rsp in the same cycle as the IDLE → ACTIVE load: the old tx_buf is sent, the new value is stored, and rsp_pend stays 1.
- **clr_rdy.** Clears frm_rdy. If clr_rdy coincides with a CHECK set, the set wins.
- **Reset.** All outputs go to 0: MISO, cfg_data, frm_rdy, rsp_pend, frm_err. FSM = IDLE; tx_buf, rx_shift and tx_shift = 0.
- **Reset mid-frame.** If SS_n is still low when rst_n releases, the reset values of the synchronizer produce a fall and the FSM enters ACTIVE with a partial bit count. The frame therefore ends with frm_err and is discarded.

## Timing

- **Host constraints:**
  - SCLK high and low phases ≥ 4 clk periods;
  - SS_n setup to the first SCLK rise ≥ 4 clk periods;
  - last SCLK fall to SS_n rise ≥ 4 clk periods;
  - SS_n high between frames ≥ 6 clk periods.
- **Frame-end latency.** If clk edge N is the first to capture SS_n = 1:
  - CHECK is entered at edge N+2;
  - frm_rdy and cfg_data update at edge N+3;
  - frm_err is high for the cycle after edge N+3.
- **MISO latency.** MISO changes at clk edge N+3 after the clk edge N that first captures the SCLK fall. The host samples MISO on its SCLK rise.
- **Control inputs.** clr_rdy and snd_rsp take effect at the next clk edge.

## Structure

- **Shared package `cmd_pkg`.** Holds:
  - FRM_BITS and RSP_BITS;
  - the opcode field position cfg_data[23:14];
  - opcode constants NEW_XSET, START_CM, WRT_EEP, READ_EEP (with address field [17:16]), shared with the control state machine;
  - the FSM state enum.
- **Sub-module `sync_edge`.** 2-flop synchronizer plus history flop, with a reset-value parameter and outputs sync, rise, fall. Instanced for SS_n, SCLK and MOSI; the MOSI instance uses the sync output only.

## Test plan

- **Good frame.** Send 24'hC0_3A5C, then wait 3 clk → frm_rdy = 1, cfg_data = 24'hC03A5C, frm_err = 0. Pulse clr_rdy → frm_rdy = 0 and cfg_data holds.
- **Response.** snd_rsp with rsp_data = 16'h2ABC, then a 24-bit frame → MISO bits 1–16 = 0x2ABC MSB first, bits 17–24 = 0; rsp_pend goes 1 → 0 at frame start. The next frame returns 0x0000.
- **Bad length.** Frames of 23 and 25 bits → frm_err pulses once each; cfg_data and frm_rdy unchanged.
- **Overrun and collision.**
  - Two good frames (0x000C00, then 0x00C000) with no clr_rdy → cfg_data = 0x00C000, frm_rdy = 1, frm_err pulses on the second.
  - clr_rdy in the same cycle as CHECK → frm_rdy = 1.
- **snd_rsp collision.** snd_rsp (0x1111) before the frame, then a second snd_rsp (0x2222) in the cycle of the frame-start load → 0x1111 is sent, rsp_pend = 1, and the next frame sends 0x2222.
- **Reset mid-frame.** Assert rst_n after 10 bits with SS_n held low, release, clock 14 more bits, raise SS_n → frm_err pulses and frm_rdy = 0. A following clean frame is accepted normally.
